multicycle_control: RTL
=======================

# multicycle_control

Multicycle control FSM for the MIPS core. It replaces single-cycle decoding with a state machine that sequences the shared datapath over several cycles per instruction: fetch, decode, address/execute, memory access and writeback. It drives the mux selects, write enables and ALU operation class, and waits on a single unified memory port through a request/ready handshake. Supported instructions are R-type, LW, SW, BEQ, ADDI and J; any other opcode is flagged and skipped.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; state←FETCH, all outputs forced 0 while high
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memwrite  out  1  memory write strobe, valid with mem_req
- irwrite  out  1  instruction register load
- regdst  out  1  write register select: 1=rd, 0=rt
- memtoreg  out  1  writeback data select: 1=Data, 0=ALUOut
- regwrite  out  1  register file write
- alusrca  out  1  ALU A select: 0=PC, 1=A
- alusrcb  out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- aluop  out  2  00=add, 01=sub, 10=funct
- pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
- pcen  out  1  PC load = pcwrite | (branch & zero)
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state  out  4  current state encoding (debug)

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH on the next edge, with all outputs 0.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
- Any output not listed for a state is 0.
- FETCH
  - Outputs: mem_req=1, alusrcb=01.
  - If mem_ready: irwrite=1, pcwrite=1, then →DECODE. Otherwise stay in FETCH.
- DECODE
  - Outputs: alusrcb=11.
  - Next state: LW/SW→MEMADR, R→EXECUTE, BEQ→BRANCH, ADDI→ADDIEX, J→JUMP.
  - Any other opcode: illegal_op=1, →FETCH.
- MEMADR
  - Outputs: alusrca=1, alusrcb=10.
  - Next state: LW→MEMRD, SW→MEMWR.
- MEMRD
  - Outputs: mem_req=1, iord=1.
  - Holds until mem_ready, then →MEMWB.
- MEMWB
  - Outputs: memtoreg=1, regwrite=1.
  - →FETCH.
- MEMWR
  - Outputs: mem_req=1, iord=1, memwrite=1, held through the wait.
  - Holds until mem_ready, then →FETCH.
- EXECUTE
  - Outputs: alusrca=1, aluop=10.
  - →ALUWB.
- ALUWB
  - Outputs: regdst=1, regwrite=1.
  - →FETCH.
- BRANCH
  - Outputs: alusrca=1, aluop=01, pcsrc=01, branch=1; pcen=zero.
  - →FETCH.
- ADDIEX
  - Outputs: alusrca=1, alusrcb=10.
  - →ADDIWB.
- ADDIWB
  - Outputs: regwrite=1.
  - →FETCH.
- JUMP
  - Outputs: pcsrc=10, pcwrite=1.
  - →FETCH.
- Output structure:
  - All outputs are combinational from state, plus mem_ready, zero and opcode where stated above.
  - state is the register value.

## Timing
- Next-state register updates on the rising clk edge. reset acts immediately, without waiting for clk.
- Handshake:
  - mem_req rises on entry to FETCH, MEMRD or MEMWR and stays high until the cycle in which mem_ready=1.
  - The access completes in that same cycle, and mem_req is dropped from the next cycle unless the new state is also a memory state.
  - mem_ready is ignored in all other states.
- Cycles per instruction with mem_ready tied 1: R=4, LW=5, SW=4, BEQ=3, ADDI=4, J=3, illegal=2.
- Each wait cycle on a memory state adds 1.
- Back-to-back instructions: the terminal state of one instruction is followed directly by FETCH, with no bubble.
- Reset mid-instruction:
  - The current operation is abandoned and no write strobe is issued.
  - After release, the first edge evaluates FETCH.
- In BRANCH, pcen follows zero combinationally within the cycle.

## Test plan
- Reset: assert reset while in MEMWR → all outputs 0 at once, state=0. Release with mem_ready=1 → irwrite=pcen=1 in the first cycle.
- R-type, mem_ready=1: state sequence 0,1,6,7,0. In ALUWB, regdst=regwrite=1 and aluop=0. In EXECUTE, aluop=10.
- LW with mem_ready low for 3 cycles in MEMRD: sequence 0,1,2,3,3,3,3,4,0. mem_req=iord=1 across all MEMRD cycles; regwrite=memtoreg=1 in MEMWB.
- BEQ with zero=1 → pcen=1, pcsrc=01 in BRANCH. Repeat with zero=0 → pcen=0. Both return to FETCH after 3 cycles.
- J: pcsrc=10, pcen=1 in JUMP. ADDI: sequence 0,1,9,10,0 with alusrcb=10 in ADDIEX.
- opcode=111111: illegal_op pulses for one cycle in DECODE, next state FETCH, no regwrite or memwrite at any point.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control
//   Multicycle MIPS control FSM. It sequences the shared datapath through
//   fetch, decode, address/execute, memory and writeback states, and waits
//   on a single unified memory port through a mem_req / mem_ready handshake.
//   Supported opcodes: R-type, LW, SW, BEQ, ADDI, J. Any other opcode raises
//   illegal_op for one cycle in DECODE and returns to FETCH.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high; forces FETCH and all outputs 0
//   opcode     in   [5:0] IR[31:26], stable from DECODE until the next FETCH
//   zero       in   ALU zero flag
//   mem_ready  in   memory completes the current request this cycle
//   mem_req    out  memory access request
//   iord       out  memory address select (0=PC, 1=ALUOut)
//   memwrite   out  memory write strobe, valid with mem_req
//   irwrite    out  instruction register load
//   regdst     out  write register select (1=rd, 0=rt)
//   memtoreg   out  writeback data select (1=Data, 0=ALUOut)
//   regwrite   out  register file write
//   alusrca    out  ALU A select (0=PC, 1=A)
//   alusrcb    out  [1:0] ALU B select (00=B, 01=4, 10=SignImm, 11=SignImm<<2)
//   aluop      out  [1:0] 00=add, 01=sub, 10=funct
//   pcsrc      out  [1:0] 00=ALUResult, 01=ALUOut, 10=jump target
//   pcen       out  PC load = pcwrite | (branch & zero)
//   illegal_op out  one-cycle pulse in DECODE on an unsupported opcode
//   state      out  [3:0] current state encoding (debug)

module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t state_q;
   state_t state_d;
   logic   pcwrite;
   logic   branch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next-state logic. Unused encodings 12-15 fall into the default and
   // recover to FETCH on the next edge.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LW)      state_d = S_MEMRD;
            else if (opcode == OP_SW) state_d = S_MEMWR;
            else                      state_d = S_FETCH;
         end
         S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE: state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
   end

   // Output decode. Everything is held at 0 while reset is high so that an
   // abandoned MEMWR cannot leave a write strobe on the bus, even though the
   // state register already reads FETCH.
   always_comb begin
      mem_req    = 1'b0;
      iord       = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      illegal_op = 1'b0;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               alusrcb = 2'b01;
               irwrite = mem_ready;
               pcwrite = mem_ready;
            end
            S_DECODE: begin
               alusrcb = 2'b11;
               illegal_op = !(opcode == OP_R  || opcode == OP_LW   ||
                              opcode == OP_SW || opcode == OP_BEQ  ||
                              opcode == OP_ADDI || opcode == OP_J);
            end
            S_MEMADR: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            S_MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            S_MEMWB: begin
               memtoreg = 1'b1;
               regwrite = 1'b1;
            end
            S_MEMWR: begin
               mem_req  = 1'b1;
               iord     = 1'b1;
               memwrite = 1'b1;
            end
            S_EXECUTE: begin
               alusrca = 1'b1;
               aluop   = 2'b10;
            end
            S_ALUWB: begin
               regdst   = 1'b1;
               regwrite = 1'b1;
            end
            S_BRANCH: begin
               alusrca = 1'b1;
               aluop   = 2'b01;
               pcsrc   = 2'b01;
               branch  = 1'b1;
            end
            S_ADDIEX: begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
            end
            S_ADDIWB: begin
               regwrite = 1'b1;
            end
            S_JUMP: begin
               pcsrc   = 2'b10;
               pcwrite = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign pcen  = pcwrite | (branch & zero);
   assign state = state_q;

endmodule
